// File: rtl/ssd_capture.sv
// ssd_capture: recovers the digit values shown on a multiplexed 7-segment display
// by debouncing anode/cathode samples. Define SSD_CAPTURE_ERROR_EN for the sticky error flag.
module ssd_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      ssd_capture_clk,
    input  logic                      ssd_capture_rst,
    input  logic [6:0]                ssd_capture_iport_cc,
    input  logic [NUM_DIGITS-1:0]     ssd_capture_iport_an,
    output logic [4*NUM_DIGITS-1:0]   ssd_capture_oport_digits,
    output logic [NUM_DIGITS-1:0]     ssd_capture_oport_valid_mask,
    output logic                      ssd_capture_oport_frame_done,
    output logic                      ssd_capture_oport_error
);

    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_cc;
    logic [7:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_frame_done;

    logic                    w_same;
    logic                    w_accept;
    logic                    w_hit;
    logic [3:0]              w_val;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_idle;
    logic                    w_single;
    logic                    w_write;
    logic [NUM_DIGITS-1:0]   w_seen_next;

    // The incoming sample is compared with the one already held, so a pattern first
    // registered on edge k drives the counter to STABLE_CYCLES on edge k+STABLE_CYCLES.
    assign w_same   = (ssd_capture_iport_an == r_an) && (ssd_capture_iport_cc == r_cc);
    assign w_accept = w_same && (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_hit = 1'b1;
        w_val = 4'h0;
        case (r_cc)
            7'h40: w_val = 4'h0;
            7'h79: w_val = 4'h1;
            7'h24: w_val = 4'h2;
            7'h30: w_val = 4'h3;
            7'h19: w_val = 4'h4;
            7'h12: w_val = 4'h5;
            7'h02: w_val = 4'h6;
            7'h78: w_val = 4'h7;
            7'h00: w_val = 4'h8;
            7'h10: w_val = 4'h9;
            7'h08: w_val = 4'hA;
            7'h03: w_val = 4'hB;
            7'h46: w_val = 4'hC;
            7'h21: w_val = 4'hD;
            7'h06: w_val = 4'hE;
            7'h0E: w_val = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    assign w_sel       = ~r_an;
    assign w_idle      = (w_sel == '0);
    assign w_single    = $onehot(w_sel);
    assign w_write     = w_accept && w_single && w_hit;
    assign w_seen_next = r_seen | (w_write ? w_sel : '0);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge ssd_capture_clk) begin
        if (ssd_capture_rst) begin
            r_an         <= '1;
            r_cc         <= '1;
            r_cnt        <= '0;
            r_digits     <= '0;
            r_valid      <= '0;
            r_seen       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= ssd_capture_iport_an;
            r_cc         <= ssd_capture_iport_cc;
            r_frame_done <= 1'b0;
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 8'd1;
            if (w_write) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (w_sel[i]) r_digits[4*i +: 4] <= w_val;
                r_valid <= r_valid | w_sel;
                // Completing the frame pulses frame_done and restarts the seen tracking.
                if (&w_seen_next) begin
                    r_seen       <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_seen <= w_seen_next;
                end
            end
        end
    end

    assign ssd_capture_oport_digits     = r_digits;
    assign ssd_capture_oport_valid_mask = r_valid;
    assign ssd_capture_oport_frame_done = r_frame_done;

`ifdef SSD_CAPTURE_ERROR_EN
    logic w_proto_err;
    logic r_error;

    // Blank (7F) is legal on a single digit; several active anodes are always an error.
    assign w_proto_err = w_accept &&
                         ((!w_idle && !w_single) ||
                          (w_single && !w_hit && (r_cc != 7'h7F)));

    always_ff @(posedge ssd_capture_clk) begin
        if (ssd_capture_rst)
            r_error <= 1'b0;
        else if (w_proto_err)
            r_error <= 1'b1;
    end

    assign ssd_capture_oport_error = r_error;
`else
    assign ssd_capture_oport_error = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_capture.sv
// Scoreboard bench for ssd_capture: stimulus pushes expected output snapshots,
// a negedge monitor pops one whenever the outputs change, pulse, or a probe is requested.
module tb_ssd_capture;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  mask;
        logic        fd;
        logic        err;
    } obs_t;

`ifdef SSD_CAPTURE_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  cc  = 7'h7F;
    logic [7:0]  an  = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  mask;
    logic        fd;
    logic        err;

    always #5 clk = ~clk;

    ssd_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .ssd_capture_clk             (clk),
        .ssd_capture_rst             (rst),
        .ssd_capture_iport_cc        (cc),
        .ssd_capture_iport_an        (an),
        .ssd_capture_oport_digits    (digits),
        .ssd_capture_oport_valid_mask(mask),
        .ssd_capture_oport_frame_done(fd),
        .ssd_capture_oport_error     (err)
    );

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    probe_cnt   = 0;
    int    probe_done  = 0;
    int    end_cnt     = 0;
    int    end_done    = 0;
    bit    mon_en      = 1'b0;

    // Reference model of the visible state
    logic [31:0] e_digits = '0;
    logic [7:0]  e_mask   = '0;
    logic        e_err    = 1'b0;

    // Monitor: the only process that counts comparisons
    obs_t  cur, last, expv;
    string nm;
    bit    primed = 1'b0;
    bit    evt;
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {digits, mask, fd, err};
            evt = primed && ((cur.digits !== last.digits) || (cur.mask !== last.mask) ||
                             (cur.err !== last.err) || (cur.fd === 1'b1));
            if (evt || (probe_cnt != probe_done)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got digits=%h mask=%h fd=%b err=%b, no expectation queued",
                             cur.digits, cur.mask, cur.fd, cur.err);
                end else begin
                    expv = exp_q.pop_front();
                    nm   = name_q.pop_front();
                    if (cur !== expv) begin
                        miscompares++;
                        $display("FAIL %s: got digits=%h mask=%h fd=%b err=%b, want digits=%h mask=%h fd=%b err=%b",
                                 nm, cur.digits, cur.mask, cur.fd, cur.err,
                                 expv.digits, expv.mask, expv.fd, expv.err);
                    end
                end
                probe_done = probe_cnt;
            end
            if (end_cnt != end_done) begin
                vectors++;
                if (exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
                end
                end_done = end_cnt;
            end
            last   = cur;
            primed = 1'b1;
        end
    end

    task automatic expect_now(input string n, input logic fdv);
        exp_q.push_back({e_digits, e_mask, fdv, e_err});
        name_q.push_back(n);
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] c, input int n);
        an = a;
        cc = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect the outputs to equal the model at the next monitor sample
    task automatic probe(input string n);
        expect_now(n, 1'b0);
        probe_cnt++;
        for (int i = 0; i < 4 && probe_done != probe_cnt; i++) begin
            @(negedge clk);
            #1;
        end
        if (probe_done != probe_cnt) begin
            $display("FAIL %s: probe not serviced, got no sample, want one", n);
            $fatal(1, "monitor stalled");
        end
    endtask

    // Capture value v on digit d (cathode code c); fdv is the hand-computed frame_done
    task automatic cap(input int d, input logic [3:0] v, input logic [6:0] c, input logic fdv,
                       input string n);
        logic [7:0] a;
        a = ~(8'(1) << d);
        e_digits[4*d +: 4] = v;
        e_mask[d] = 1'b1;
        expect_now(n, fdv);
        hold(a, c, 6);
    endtask

    task automatic do_reset(input string n);
        e_digits = '0;
        e_mask   = '0;
        e_err    = 1'b0;
        expect_now(n, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        probe("reset_state");

        // Single digit, accept lands exactly on the 4th edge after the first sample
        hold(8'hFE, 7'h30, 4);
        probe("before_accept");
        e_digits[3:0] = 4'h3;
        e_mask[0]     = 1'b1;
        expect_now("first_accept", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        hold(8'hFF, 7'h7F, 6);

        // Full scan 0..7 with values 1..8, one frame pulse on digit 7
        cap(0, 4'h1, 7'h79, 1'b0, "scan1_d0");
        cap(1, 4'h2, 7'h24, 1'b0, "scan1_d1");
        cap(2, 4'h3, 7'h30, 1'b0, "scan1_d2");
        cap(3, 4'h4, 7'h19, 1'b0, "scan1_d3");
        cap(4, 4'h5, 7'h12, 1'b0, "scan1_d4");
        cap(5, 4'h6, 7'h02, 1'b0, "scan1_d5");
        cap(6, 4'h7, 7'h78, 1'b0, "scan1_d6");
        cap(7, 4'h8, 7'h00, 1'b1, "scan1_d7_frame");
        hold(8'hFF, 7'h7F, 6);
        probe("scan1_final");

        // Seen mask restarted: re-scanning identical values pulses again only on digit 7
        for (int d = 0; d < 7; d++) begin
            logic [7:0] a;
            logic [6:0] codes [8];
            codes = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
            a = ~(8'(1) << d);
            hold(a, codes[d], 6);
        end
        cap(7, 4'h8, 7'h00, 1'b1, "rescan_frame");
        hold(8'hFF, 7'h7F, 6);

        // Unstable cathodes never reach the threshold
        for (int i = 0; i < 5; i++) begin
            hold(8'hFE, 7'h30, 2);
            hold(8'hFE, 7'h24, 2);
        end
        hold(8'hFF, 7'h7F, 6);
        probe("unstable_no_accept");

        // Blank pattern on a single digit is silently ignored
        hold(8'hFD, 7'h7F, 10);
        hold(8'hFF, 7'h7F, 6);
        probe("blank_ignored");

        // Two anodes low is a protocol error
        e_err = ERR_EN;
        if (ERR_EN) expect_now("multi_anode_error", 1'b0);
        hold(8'hFC, 7'h00, 6);
        hold(8'hFF, 7'h7F, 10);
        probe("error_sticky");

        // Unknown segment pattern on a single digit updates nothing
        hold(8'hFB, 7'h7E, 6);
        hold(8'hFF, 7'h7F, 6);
        probe("bad_pattern_no_update");

        // Partial frame with hex letters, then reset discards it
        cap(0, 4'hA, 7'h08, 1'b0, "part_d0_A");
        cap(1, 4'hB, 7'h03, 1'b0, "part_d1_b");
        cap(2, 4'hC, 7'h46, 1'b0, "part_d2_C");
        cap(3, 4'hD, 7'h21, 1'b0, "part_d3_d");
        hold(8'hFF, 7'h7F, 6);
        do_reset("mid_frame_reset");
        hold(8'hFF, 7'h7F, 6);

        // Full scan in order 4..7,0..3: the only pulse is on digit 3
        cap(4, 4'hE, 7'h06, 1'b0, "scan2_d4");
        cap(5, 4'hF, 7'h0E, 1'b0, "scan2_d5");
        cap(6, 4'h0, 7'h40, 1'b0, "scan2_d6");
        cap(7, 4'h9, 7'h10, 1'b0, "scan2_d7");
        cap(0, 4'h8, 7'h00, 1'b0, "scan2_d0");
        cap(1, 4'h7, 7'h78, 1'b0, "scan2_d1");
        cap(2, 4'h6, 7'h02, 1'b0, "scan2_d2");
        cap(3, 4'h5, 7'h12, 1'b1, "scan2_d3_frame");
        hold(8'hFF, 7'h7F, 10);
        probe("final_state");

        end_cnt++;
        for (int i = 0; i < 4 && end_done != end_cnt; i++) @(posedge clk);
        if (end_done != end_cnt) begin
            $display("FAIL end_check: not serviced, got none, want one");
            $fatal(1, "monitor stalled");
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digit positions captured.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, legal range 1 to 255: consecutive identical samples needed to accept a digit.
REQ-003 SHALL have port ssd_capture_clk, input, 1 bit: system clock, 100 MHz, all logic on its rising edge.
REQ-004 SHALL have port ssd_capture_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port ssd_capture_iport_cc, input, 7 bits: segment cathodes, active-low, bit6=g down to bit0=a.
REQ-006 SHALL have port ssd_capture_iport_an, input, NUM_DIGITS bits: anode selects, active-low, bit i = digit i.
REQ-007 SHALL have port ssd_capture_oport_digits, output, 4*NUM_DIGITS bits: decoded value of digit i at [4i+3:4i].
REQ-008 SHALL have port ssd_capture_oport_valid_mask, output, NUM_DIGITS bits: bit i set once digit i has been accepted since reset.
REQ-009 SHALL have port ssd_capture_oport_frame_done, output, 1 bit: one-cycle pulse when every digit has been accepted since the previous pulse.
REQ-010 SHALL have port ssd_capture_oport_error, output, 1 bit: sticky protocol-error flag.

Function
REQ-011 SHALL register an and cc once per clock; all following logic uses these registered samples only.
REQ-012 SHALL hold a stability counter, saturating at STABLE_CYCLES, that clears whenever the sample differs from the previous sample and increments otherwise.
REQ-013 SHALL accept exactly once per stable window, on the edge where the counter reaches STABLE_CYCLES, so a new sample first seen on edge k updates the outputs on edge k+STABLE_CYCLES.
REQ-014 SHALL decode cc, hex for bit6..0, as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-015 SHALL, on accept with exactly one an bit low and a cc pattern in the table, write that digit field, set its valid_mask bit and set its seen bit; other fields are unchanged.
REQ-016 SHALL, on accept with all an bits high (idle) or cc=7F (blank), update no field and raise no error.
REQ-017 SHALL treat as a protocol error an accept with more than one an bit low, or with exactly one an bit low and a cc pattern that is neither in the table nor 7F; in that case no field is updated.
REQ-018 SHALL keep an internal seen mask; when an accept completes it to all ones, frame_done SHALL be 1 on that same edge and the seen mask SHALL clear to zero on that same edge.
REQ-019 SHALL keep frame_done low on every other cycle; a repeated accept of an already-seen digit SHALL neither set nor clear any seen bit.
REQ-020 SHALL give the 4-bit value of each digit directly as stored; no BCD range check is applied.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, clear digits to all zeros, valid_mask to zero, seen mask to zero, frame_done to 0, error to 0, the stability counter to 0, and the sample registers to all ones (idle).
REQ-022 SHALL let rst take priority over any accept on the same edge, including a reset during a partially captured frame, which discards all progress.

Configuration
REQ-023 SHALL, with SSD_CAPTURE_ERROR_EN defined, set error on every protocol error; error stays at 1 until reset.
REQ-024 SHALL, without SSD_CAPTURE_ERROR_EN, tie error to constant 0 and drop protocol errors silently; all other behaviour is identical.

Verification
REQ-025 Bench: reset, then an=FE and cc=30 held for 4 cycles -> digits[3:0]=3 on the 4th edge after the first sample, valid_mask=01, frame_done=0.
REQ-026 Bench: scan digits 0..7 with values 1..8, each held 6 cycles -> exactly one frame_done pulse, on the accept of digit 7; digits=0x87654321; seen mask clears.
REQ-027 Bench: an=FE with cc alternating 30/24 every 2 cycles for 20 cycles -> no accept; digits and valid_mask unchanged; error=0.
REQ-028 Bench: an=FC with cc=00 held 4 cycles, SSD_CAPTURE_ERROR_EN defined -> error=1 and stays 1; no digit updated. Same test without the macro -> error=0.
REQ-029 Bench: capture digits 0..3, then rst=1 for 1 cycle -> all outputs 0; a later full 8-digit scan gives exactly one frame_done.
REQ-030 Bench: an=FD with cc=7F held 10 cycles, then all an high -> no field update, no error, valid_mask unchanged.
